// File: rtl/pl_mem_loader.sv
// Byte-stream loader: holds the CPU in reset, writes little-endian words to data
// memory, and releases the CPU only after the XOR checksum matches.
//
// state | meaning
// IDLE  | waiting for start, CPU held
// HDR0  | accept word count N[7:0]
// HDR1  | accept word count N[15:8], validate N
// DATA  | accept payload bytes into the word shift register
// WRITE | single-cycle memory write strobe
// CSUM  | accept checksum byte and compare
// GUARD | two quiet cycles before releasing the CPU
// DONE  | load succeeded, CPU running
// ERR   | load failed, CPU held
module pl_mem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        cpu_rst,
  output logic        ext_memwr_sgn,
  output logic [31:0] ext_datamem_wr,
  output logic [31:0] ext_datamem_rd,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded
);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_WRITE, S_CSUM, S_GUARD, S_DONE, S_ERR
  } state_t;

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  state_t      state, state_nxt;
  logic [15:0] hdr_n, hdr_n_nxt;
  logic [23:0] word_sr, word_nxt;
  logic [1:0]  byte_idx, idx_nxt;
  logic [7:0]  checksum, csum_nxt;
  logic        guard_cnt, guard_nxt;
  logic [15:0] wl_nxt;
  logic [31:0] wdata_nxt, addr_nxt;
  logic        in_ready_nxt, cpu_rst_nxt, memwr_nxt, busy_nxt, done_nxt, err_nxt;
  logic        accept;
  logic [15:0] n_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      hdr_n          <= '0;
      word_sr        <= '0;
      byte_idx       <= '0;
      checksum       <= '0;
      guard_cnt      <= 1'b0;
      words_loaded   <= '0;
      in_ready       <= 1'b0;
      cpu_rst        <= 1'b1;
      ext_memwr_sgn  <= 1'b0;
      ext_datamem_wr <= '0;
      ext_datamem_rd <= BASE_ADDR;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      state          <= state_nxt;
      hdr_n          <= hdr_n_nxt;
      word_sr        <= word_nxt;
      byte_idx       <= idx_nxt;
      checksum       <= csum_nxt;
      guard_cnt      <= guard_nxt;
      words_loaded   <= wl_nxt;
      in_ready       <= in_ready_nxt;
      cpu_rst        <= cpu_rst_nxt;
      ext_memwr_sgn  <= memwr_nxt;
      ext_datamem_wr <= wdata_nxt;
      ext_datamem_rd <= addr_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      err            <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hdr_n_nxt = hdr_n;
    word_nxt  = word_sr;
    idx_nxt   = byte_idx;
    csum_nxt  = checksum;
    guard_nxt = guard_cnt;
    wl_nxt    = words_loaded;
    wdata_nxt = ext_datamem_wr;
    accept    = in_valid && in_ready;
    n_full    = {in_data, hdr_n[7:0]};
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_nxt = S_HDR0;
          wl_nxt    = '0;
          csum_nxt  = '0;
          idx_nxt   = '0;
        end
      end
      S_HDR0: begin
        if (accept) begin
          hdr_n_nxt[7:0] = in_data;
          state_nxt      = S_HDR1;
        end
      end
      S_HDR1: begin
        if (accept) begin
          hdr_n_nxt = n_full;
          if (n_full == 16'd0)    state_nxt = S_CSUM;
          else if (n_full > MAX_N) state_nxt = S_ERR;
          else                     state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_nxt = checksum ^ in_data;
          idx_nxt  = byte_idx + 2'd1;
          // bytes enter at the top so the first byte ends up in [7:0]
          if (byte_idx == 2'd3) begin
            wdata_nxt = {in_data, word_sr};
            state_nxt = S_WRITE;
          end else begin
            word_nxt = {in_data, word_sr[23:8]};
          end
        end
      end
      S_WRITE: begin
        wl_nxt = words_loaded + 16'd1;
        state_nxt = (wl_nxt == hdr_n) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (accept) begin
          if (in_data == checksum) begin
            state_nxt = S_GUARD;
            guard_nxt = 1'b1;
          end else begin
            state_nxt = S_ERR;
          end
        end
      end
      S_GUARD: begin
        if (guard_cnt == 1'b0) state_nxt = S_DONE;
        else                   guard_nxt = guard_cnt - 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // outputs are decoded from the next state so the registered copies line up with it
  always_comb begin
    in_ready_nxt = (state_nxt == S_HDR0) || (state_nxt == S_HDR1) ||
                   (state_nxt == S_DATA) || (state_nxt == S_CSUM);
    busy_nxt     = (state_nxt == S_HDR0) || (state_nxt == S_HDR1) ||
                   (state_nxt == S_DATA) || (state_nxt == S_WRITE) ||
                   (state_nxt == S_CSUM) || (state_nxt == S_GUARD);
    cpu_rst_nxt  = (state_nxt != S_DONE);
    memwr_nxt    = (state_nxt == S_WRITE);
    done_nxt     = (state_nxt == S_DONE);
    err_nxt      = (state_nxt == S_ERR);
    addr_nxt     = BASE_ADDR + 32'({wl_nxt, 2'b00});
  end

endmodule

// File: doc/pl_mem_loader.md
Name: pl_mem_loader

Overview:
Byte-stream program/data loader that sits directly upstream of the pipelined RISC-V top level. It drives that block's external memory-write path and its CPU reset.
- Holds the CPU in reset while loading.
- Assembles incoming bytes into little-endian 32-bit words.
- Writes each word to consecutive data-memory addresses.
- Verifies an XOR checksum before releasing the CPU.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first word written
MAX_WORDS, 1024, largest accepted word count; a header above this is an error

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous active-high reset
start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERR
in_valid  input  1  byte available on in_data
in_data  input  8  stream byte
in_ready  output  1  loader accepts a byte this cycle; transfer when in_valid && in_ready
cpu_rst  output  1  drives the CPU top-level rst; 1 = CPU held and external memory path selected
ext_memwr_sgn  output  1  one-cycle write strobe to data memory
ext_datamem_wr  output  32  write data
ext_datamem_rd  output  32  byte address presented to data memory while cpu_rst=1
busy  output  1  load in progress (HDR0..GUARD)
done  output  1  last load succeeded; CPU released
err  output  1  last load failed
words_loaded  output  16  words written in current/last load

Behaviour:
Reset values:
- On clk edge with rst=1: state=IDLE, cpu_rst=1, in_ready=0, ext_memwr_sgn=0, ext_datamem_wr=0, ext_datamem_rd=BASE_ADDR, busy=0, done=0, err=0, words_loaded=0, byte index=0, checksum=0.
- All outputs are registered.

States: IDLE, HDR0, HDR1, DATA, WRITE, CSUM, GUARD, DONE, ERR.

IDLE / DONE / ERR:
- start -> HDR0.
- On entry to HDR0: clear done, err, words_loaded, checksum and byte index; cpu_rst=1.
- start in any other state is ignored.
- IDLE keeps cpu_rst=1.

Header (HDR0, HDR1):
- in_ready=1.
- HDR0 accepts N[7:0]; HDR1 accepts N[15:8].
- From HDR1: N=0 -> CSUM; N>MAX_WORDS -> ERR; else -> DATA.

DATA:
- in_ready=1.
- Accepted bytes fill the word shift register little-endian (byte0 -> [7:0] ... byte3 -> [31:24]).
- Each data byte is XORed into the checksum.
- On the 4th accepted byte -> WRITE.

WRITE (exactly 1 cycle):
- ext_memwr_sgn=1, ext_datamem_wr=assembled word, ext_datamem_rd=BASE_ADDR+4*words_loaded, in_ready=0.
- Next cycle: words_loaded increments and ext_memwr_sgn returns to 0.
- If the new count == N -> CSUM; else -> DATA.

CSUM:
- in_ready=1; accepts one byte.
- Equal to the running checksum -> GUARD; else -> ERR.

GUARD (2 cycles):
- cpu_rst=1, no writes, in_ready=0.
- Then -> DONE.

DONE:
- cpu_rst=0, done=1, busy=0.

ERR:
- cpu_rst=1, err=1, busy=0.
- Words already written stay in memory; they are not rolled back.

Flow control and boundaries:
- in_valid low stalls indefinitely in any byte-accepting state; no timeout.
- Byte accepted only when in_valid && in_ready. in_data is ignored otherwise.
- Address wraps modulo 2^32 (no wrap occurs within MAX_WORDS at default base).
- rst mid-load: immediate return to reset values. A write in progress is aborted after the current cycle; no further strobes. The CPU stays held.
- ext_memwr_sgn is never high while cpu_rst=0.

Test Plan:
1. Apply rst 3 cycles -> cpu_rst=1, in_ready=0, ext_memwr_sgn=0, busy/done/err=0, ext_datamem_rd=0, words_loaded=0.
2. start; bytes 02 00 78 56 34 12 EF BE AD DE 2A ->
   - strobe with addr 0x0 / data 0x12345678;
   - strobe with addr 0x4 / data 0xDEADBEEF;
   - in_ready=0 on each write cycle;
   - 2 guard cycles, then done=1, cpu_rst=0, words_loaded=2.
3. Same stream with checksum 2B -> both writes occur; err=1, done=0, cpu_rst stays 1. A following start plus a correct stream -> done=1.
4. Header 00 00 then checksum 00 -> no write strobe; done=1. Header 01 04 (1025 words) -> err=1 immediately after HDR1; no strobe.
5. Insert random in_valid gaps of 0-5 cycles in scenario 2 -> identical writes and result. A start pulse mid-DATA is ignored.
6. Assert rst after 6 data bytes -> only the first word is written. State returns to IDLE with reset values, and no strobe follows.
